// File: rtl/nco_quarter_wave_pkg.sv
// Shared CostasLoop NCO definitions.
// Phase width, default output/ROM sizes and quadrant encoding.
package nco_quarter_wave_pkg;

  localparam int PHASE_W    = 30;
  localparam int OUT_W_DEF  = 12;
  localparam int LUT_AW_DEF = 8;

  typedef enum logic [1:0] {
    QUAD0 = 2'd0,
    QUAD1 = 2'd1,
    QUAD2 = 2'd2,
    QUAD3 = 2'd3
  } quad_e;

endpackage

// File: rtl/nco_sin_rom.sv
// Quarter-wave sine ROM, registered read.
// Entries sample mid-bin so L[k] and L[~k] are mirror images.
module nco_sin_rom #(
  parameter int OUT_W  = 12,
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [OUT_W-2:0]  data_o
);

  localparam int DEPTH = 2 ** LUT_AW;

  function automatic logic [OUT_W-2:0] entry(input int k);
    real amp;
    real ang;
    amp = (2.0 ** (OUT_W - 1)) - 1.0;
    ang = 2.0 * 3.141592653589793 * (real'(k) + 0.5)
        / (2.0 ** (LUT_AW + 2));
    return (OUT_W-1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [OUT_W-2:0] V = entry(k);
    assign rom[k] = V;
  end

  always_ff @(posedge clk) begin
    data_o <= rom[addr_i];
  end

endmodule

// File: rtl/nco_quarter_wave.sv
// Quarter-wave NCO: phase accumulator plus 3-stage sin/cos pipeline.
// The sample for a ce cycle uses the pre-increment phase.
module nco_quarter_wave
  import nco_quarter_wave_pkg::*;
#(
  parameter logic [PHASE_W-1:0] START_FREQ = 30'h1000_0000,
  parameter int                 OUT_W      = OUT_W_DEF,
  parameter int                 LUT_AW     = LUT_AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    freq_valid,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    phase_clr,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic                    out_valid,
  output logic [PHASE_W-1:0]      phase
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] freq_q, freq_d;

  logic               v1_q, v2_q, v3_q;
  quad_e              q1_q, q2_q;
  logic [LUT_AW-1:0]  a1_q;
  logic [OUT_W-2:0]   la, lna;

  logic signed [OUT_W-1:0] sin_q, sin_d;
  logic signed [OUT_W-1:0] cos_q, cos_d;
  logic signed [OUT_W-1:0] la_s, lna_s;

  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    if (freq_valid) freq_d = freq_word;
    if (phase_clr) phase_d = '0;
    else if (ce)   phase_d = phase_q + freq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      freq_q  <= START_FREQ;
    end else begin
      phase_q <= phase_d;
      freq_q  <= freq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      q1_q <= QUAD0;
      a1_q <= '0;
      v2_q <= 1'b0;
      q2_q <= QUAD0;
    end else begin
      v1_q <= ce;
      q1_q <= quad_e'(phase_q[PHASE_W-1 -: 2]);
      a1_q <= phase_q[PHASE_W-3 -: LUT_AW];
      v2_q <= v1_q;
      q2_q <= q1_q;
    end
  end

  // Two reads per sample: direct and mirrored address.
  nco_sin_rom #(
    .OUT_W  (OUT_W),
    .LUT_AW (LUT_AW)
  ) u_rom_a (
    .clk    (clk),
    .addr_i (a1_q),
    .data_o (la)
  );

  nco_sin_rom #(
    .OUT_W  (OUT_W),
    .LUT_AW (LUT_AW)
  ) u_rom_na (
    .clk    (clk),
    .addr_i (~a1_q),
    .data_o (lna)
  );

  assign la_s  = signed'({1'b0, la});
  assign lna_s = signed'({1'b0, lna});

  always_comb begin
    sin_d = sin_q;
    cos_d = cos_q;
    if (v2_q) begin
      unique case (q2_q)
        QUAD0: begin
          sin_d = la_s;
          cos_d = lna_s;
        end
        QUAD1: begin
          sin_d = lna_s;
          cos_d = -la_s;
        end
        QUAD2: begin
          sin_d = -la_s;
          cos_d = -lna_s;
        end
        QUAD3: begin
          sin_d = -lna_s;
          cos_d = la_s;
        end
        default: begin
          sin_d = sin_q;
          cos_d = cos_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q  <= 1'b0;
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      v3_q  <= v2_q;
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign out_valid = v3_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_nco_quarter_wave.sv
// Directed bench for nco_quarter_wave.
// Stimulus pushes expected samples; a negedge monitor pops and compares.
module tb_nco_quarter_wave;

  localparam logic [29:0] START = 30'h1000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic               freq_valid;
  logic [29:0]        freq_word;
  logic               phase_clr;
  logic signed [11:0] sin_out;
  logic signed [11:0] cos_out;
  logic               out_valid;
  logic [29:0]        phase;

  always #5 clk = ~clk;

  nco_quarter_wave #(
    .START_FREQ (START),
    .OUT_W      (12),
    .LUT_AW     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .freq_valid (freq_valid),
    .freq_word  (freq_word),
    .phase_clr  (phase_clr),
    .sin_out    (sin_out),
    .cos_out    (cos_out),
    .out_valid  (out_valid),
    .phase      (phase)
  );

  typedef struct {
    int s;
    int c;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          last_s = 0;
  int          last_c = 0;
  logic [29:0] ph_m;
  logic [29:0] fr_m;
  logic        done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) cyc=%0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Hand-computed: L[0]=6 L[255]=2047 L[127]=1443 L[128]=1452
  function automatic void exp_of(input logic [29:0] p,
                                 output int s, output int c);
    case (p)
      30'h0000_0000: begin s =     6; c =  2047; end
      30'h0800_0000: begin s =  1452; c =  1443; end
      30'h1000_0000: begin s =  2047; c =    -6; end
      30'h1800_0000: begin s =  1443; c = -1452; end
      30'h2000_0000: begin s =    -6; c = -2047; end
      30'h2800_0000: begin s = -1452; c = -1443; end
      30'h3000_0000: begin s = -2047; c =     6; end
      30'h3800_0000: begin s = -1443; c =  1452; end
      default:       begin s = 99999; c = 99999; end
    endcase
  endfunction

  task automatic tick(input logic c_i, input logic fv,
                      input logic [29:0] fw, input logic clr);
    exp_t e;
    int   s, c;
    ce         = c_i;
    freq_valid = fv;
    freq_word  = fw;
    phase_clr  = clr;
    if (c_i) begin
      exp_of(ph_m, s, c);
      e.s   = s;
      e.c   = c;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    if (clr)       ph_m = '0;
    else if (c_i)  ph_m = ph_m + fr_m;
    if (fv)        fr_m = fw;
    @(posedge clk);
    #1;
    chk("phase", int'(phase), int'(ph_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    ce         = 1'b0;
    freq_valid = 1'b0;
    freq_word  = '0;
    phase_clr  = 1'b0;
    sb.delete();
    repeat (n) @(posedge clk);
    #1;
    rst  = 1'b0;
    ph_m = '0;
    fr_m = START;
    chk("rst_phase", int'(phase), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sin", int'(sin_out), 0);
    chk("rst_cos", int'(cos_out), 0);
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        last_s = 0;
        last_c = 0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("sin", int'(sin_out), e.s);
          chk("cos", int'(cos_out), e.c);
          last_s = e.s;
          last_c = e.c;
        end
      end else begin
        chk("sin_hold", int'(sin_out), last_s);
        chk("cos_hold", int'(cos_out), last_c);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("missing_valid", int'(out_valid), 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  logic [29:0] step_a [8];

  initial begin : stim
    step_a = '{30'h1000_0000, 30'h2000_0000, 30'h3000_0000, 30'h0,
               30'h1000_0000, 30'h2000_0000, 30'h3000_0000, 30'h0};
    ph_m = '0;
    fr_m = START;

    do_reset(2);

    // Full-rate quarter steps, wraps at 2^30
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, '0, 1'b0);
      chk("phase_a", int'(phase), int'(step_a[i]));
    end
    idle(4);

    // New word coincident with ce applies one step later
    tick(1'b1, 1'b1, 30'h0800_0000, 1'b0);
    chk("phase_b0", int'(phase), 32'h1000_0000);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_b1", int'(phase), 32'h1800_0000);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_b2", int'(phase), 32'h2000_0000);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_b3", int'(phase), 32'h2800_0000);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_b4", int'(phase), 32'h3000_0000);
    idle(4);

    // Clear beats ce
    tick(1'b0, 1'b1, 30'h1000_0000, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_c0", int'(phase), 32'h2000_0000);
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("phase_c1", int'(phase), 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_c2", int'(phase), 32'h1000_0000);
    idle(4);

    // Gapped ce: valid follows, outputs hold in gaps
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    idle(4);

    // Reset with two samples in flight
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    do_reset(1);
    idle(4);
    chk("post_rst_sin", int'(sin_out), 0);
    chk("post_rst_cos", int'(cos_out), 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("phase_e", int'(phase), 32'h1000_0000);
    idle(5);

    chk("sb_empty", sb.size(), 0);
    done = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
